// File: rtl/dsp_arb_pkg.sv
// rtl/dsp_arb_pkg.sv - shared types and constants for the DSP add/sub arbiter
// Contents: state_t (ST_IDLE/ST_EXEC/ST_RESP), DATA_W, OP_ADD/OP_SUB.
package dsp_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dsp_addsub_core.sv
// rtl/dsp_addsub_core.sv - combinational 32-bit add/sub in SB_MAC16 add/sub mode
// Ports:
//   a, b   : operands (out = a + b or a - b)
//   sub    : runtime ADDSUBTOP/ADDSUBBOT control, 1 = subtract
//   out    : result modulo 2^32
//   carry  : add carry out / subtract NOT borrow
// The DSP is split into two 16-bit accumulator halves; the bottom half's
// carry feeds the top half, mirroring the tile's chained carry.
module dsp_addsub_core
    import dsp_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] out,
    output logic              carry
);

    logic [15:0] b_lo;
    logic [15:0] b_hi;
    logic [16:0] bot_sum;
    logic [16:0] top_sum;

    // Subtraction is A + ~B + 1: invert B and inject the +1 as the bottom carry-in.
    assign b_lo    = b[15:0]  ^ {16{sub}};
    assign b_hi    = b[31:16] ^ {16{sub}};
    assign bot_sum = {1'b0, a[15:0]}  + {1'b0, b_lo} + {16'd0, sub};
    assign top_sum = {1'b0, a[31:16]} + {1'b0, b_hi} + {16'd0, bot_sum[16]};

    assign out   = {top_sum[15:0], bot_sum[15:0]};
    assign carry = top_sum[16];

endmodule

// File: rtl/dsp_addsub_arbiter.sv
// rtl/dsp_addsub_arbiter.sv - round-robin arbiter sharing one DSP add/sub among requesters
// Optional feature macro: DSP_ADDSUB_FLAGS_EN (registered zero/overflow flags).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready one-hot or zero)
//   req_a, req_b        : 32-bit operand slices, slice i = requester i
//   req_sub             : per-requester op select, 1 = A-B
//   resp_valid/ready    : shared response handshake
//   resp_id             : requester index owning the result
//   resp_data/carry     : result and carry / NOT borrow
//   resp_zero/ovf       : result flags, 0 when the feature is not built
module dsp_addsub_arbiter
    import dsp_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_sub,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_carry,
    output logic                      resp_zero,
    output logic                      resp_ovf
);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_sub;
    logic [ID_W-1:0]   op_id;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    int                scan_idx;

    logic [DATA_W-1:0] core_out;
    logic              core_carry;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    // Requests are ignored while rst is high, so ready is gated by it too.
    always_comb begin
        req_ready = '0;
        if (!rst && state == ST_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    dsp_addsub_core u_core (
        .a     (op_a),
        .b     (op_b),
        .sub   (op_sub),
        .out   (core_out),
        .carry (core_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            op_id      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_carry <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        op_a   <= req_a[int'(grant_idx)*DATA_W +: DATA_W];
                        op_b   <= req_b[int'(grant_idx)*DATA_W +: DATA_W];
                        op_sub <= req_sub[grant_idx];
                        op_id  <= grant_idx;
                        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_data  <= core_out;
                    resp_carry <= core_carry;
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    // resp_data/id/carry deliberately keep their value after the handshake.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DSP_ADDSUB_FLAGS_EN
    logic flag_zero;
    logic flag_ovf;

    always_comb begin
        flag_zero = (core_out == '0);
        if (op_sub == OP_SUB) begin
            flag_ovf = (op_a[31] != op_b[31]) && (core_out[31] != op_a[31]);
        end else begin
            flag_ovf = (op_a[31] == op_b[31]) && (core_out[31] != op_a[31]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_zero <= 1'b0;
            resp_ovf  <= 1'b0;
        end else if (state == ST_EXEC) begin
            resp_zero <= flag_zero;
            resp_ovf  <= flag_ovf;
        end
    end
`else
    assign resp_zero = 1'b0;
    assign resp_ovf  = 1'b0;
`endif

endmodule

// File: doc/dsp_addsub_arbiter.md
Name: dsp_addsub_arbiter

Overview:
Shares one DSP-based 32-bit adder/subtractor (SB_MAC16 in add/sub mode) between NUM_REQ requesters, e.g. the ALU and the branch/address unit.
Each requester uses a valid/ready request channel. The block runs a round-robin arbiter and sequences one operation at a time through the DSP. It returns a registered, tagged result on a shared valid/ready response channel.
Sits between the core's execute-stage requesters and the single DSP tile.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
ID_W, 1, response tag width; must equal max(1, ceil(log2(NUM_REQ))).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset; asynchronous, active-high.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
req_a  input  32*NUM_REQ  minuend/augend; slice i belongs to requester i.
req_b  input  32*NUM_REQ  subtrahend/addend; slice i belongs to requester i.
req_sub  input  NUM_REQ  1 = A-B, 0 = A+B.
resp_valid  output  1  result valid.
resp_ready  input  1  consumer accepts result.
resp_id  output  ID_W  index of the requester that owns the result.
resp_data  output  32  result, modulo 2^32.
resp_carry  output  1  add: carry out of bit 31. Sub: NOT borrow (1 when A>=B unsigned).
resp_zero  output  1  result == 0 (feature-dependent).
resp_ovf  output  1  signed overflow (feature-dependent).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, rr_ptr=0.
  - All operand/result registers are 0.
  - resp_valid, resp_id, resp_data, resp_carry, resp_zero, resp_ovf are 0; req_ready is 0.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
  - On handshake: capture a, b, sub and id into fabric registers, set rr_ptr=(grant+1) mod NUM_REQ, go to EXEC.
  - With no valid request, remain in IDLE and leave rr_ptr unchanged.
- EXEC:
  - Registered operands drive the DSP. DSP ADDSUB controls are driven by the registered sub bit; the DSP is purely combinational (no internal regs).
  - Capture out, carry and flags into the result registers, set resp_valid=1, go to RESP.
- RESP:
  - resp_* outputs are held stable until resp_valid && resp_ready.
  - On that handshake go to IDLE and clear resp_valid the next cycle; resp_data keeps its last value.
- req_ready is 0 in EXEC and RESP. Requesters must hold valid and operands stable until accepted; withdrawing an unaccepted request is legal.
- Latency: request handshake at cycle N gives resp_valid at cycle N+2. Maximum throughput is one operation per 3 cycles.
- Simultaneous valid requests are resolved only by rr_ptr, so a continuously requesting agent waits at most NUM_REQ-1 grants.
- Width: sub computes A + ~B + 1 over 33 bits; bit 32 is resp_carry. No saturation; wrap modulo 2^32.
- Reset asserted mid-operation discards the in-flight op with no response, and the arbiter restarts from rr_ptr=0.
- req_* inputs are ignored while rst=1.

Optional Feature:
DSP_ADDSUB_FLAGS_EN.
- Defined:
  - resp_zero = (result==0).
  - resp_ovf = signed overflow: add with same-sign operands and a different-sign result, or sub with different-sign operands and result sign != A sign.
  - Both are registered with resp_data.
- Undefined: resp_zero and resp_ovf are tied to 0 and no flag logic is synthesised.

Decomposition:
- Shared package dsp_arb_pkg:
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
  - DATA_W=32.
  - Opcode constants OP_ADD=1'b0, OP_SUB=1'b1.
- Natural sub-module: dsp_addsub_core.
  - Thin SB_MAC16 wrapper with a runtime sub input driving ADDSUBTOP/ADDSUBBOT and the top/bottom carry chained.
  - Outputs out[31:0] and carry.
  - The arbiter FSM and round-robin logic stay in the top module.

Test Plan:
- Single request, req0 A=5, B=3, sub=1 -> req_ready[0] same cycle, two cycles later resp_valid=1, id=0, data=2, carry=1.
- Borrow, req1 A=3, B=5, sub=1 -> data=0xFFFFFFFE, carry=0, ovf=0, id=1.
- Add wrap, A=0xFFFFFFFF, B=1, sub=0 -> data=0, carry=1, zero=1 with FLAGS_EN (zero=0 without). A=0x7FFFFFFF, B=1 add -> ovf=1.
- Both requesters held valid for 6 ops -> grant order 0,1,0,1,0,1; no back-to-back grant to the same id while the other is waiting.
- Backpressure: resp_ready=0 for 4 cycles -> resp_valid/data/id stable, req_ready=0 throughout; accepted on the 5th cycle, IDLE next.
- rst pulsed during EXEC with req0 pending -> outputs 0 immediately, no response for the dropped op; after release, simultaneous req0/req1 grants req0 first.
